dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data-cache controller between the MEM stage and off-chip data memory. It serves loads and stores from the pipeline and refills or evicts 256-bit lines over a request/acknowledge memory port. It drives `cpu_stall_o`, the `MemStall_i` consumed by every pipeline register, and holds the whole pipeline for the duration of each miss.

---
 rtl/cache_pkg.sv | 14 +
 rtl/dcache_sram.sv | 36 +++
 rtl/dcache_controller.sv | 76 +++++++
 tb/tb_dcache_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM state encoding and tag-entry layout for the L1 data cache
package cache_pkg;
  localparam int TAG_W  = 23;
  localparam int IDX_W  = 4;
  localparam int OFS_W  = 5;
  localparam int LINES  = 16;
  localparam int LINE_W = 256;
  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE} state_t;
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: LINES x (tag entry + line) storage, async read, single sync write port
// clk_i/start_i: clock and async active-low clear of valid/dirty bits
// idx: line index; we/wentry/wline: write port; rentry/rline: async read port
module dcache_sram import cache_pkg::*; (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic [IDX_W-1:0]  idx,
  input  logic              we,
  input  tag_entry_t        wentry,
  input  logic [LINE_W-1:0] wline,
  output tag_entry_t        rentry,
  output logic [LINE_W-1:0] rline
);
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[idx] <= wentry.valid;
      dirty_q[idx] <= wentry.dirty;
    end
  end
  // tags and data are never cleared; valid gates every use of them
  always_ff @(posedge clk_i) begin
    if (we) begin
      tag_q[idx]  <= wentry.tag;
      data_q[idx] <= wline;
    end
  end
  assign rentry = {valid_q[idx], dirty_q[idx], tag_q[idx]};
  assign rline  = data_q[idx];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate L1 data-cache controller
// cpu_*: MEM-stage load/store port, cpu_stall_o holds the pipeline on a miss
// mem_*: 256-bit line fetch/write-back port with one-cycle mem_ack_i completion
module dcache_controller import cache_pkg::*; (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  state_t            state, state_nx;
  tag_entry_t        rentry, wentry;
  logic [LINE_W-1:0] rline, wline, merged;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        word;
  logic              req, hit, we, wb, rf;
  logic              unused_ok;
  assign tag       = cpu_addr_i[31:9];
  assign idx       = cpu_addr_i[8:5];
  assign word      = cpu_addr_i[4:2];
  assign unused_ok = ^cpu_addr_i[1:0];
  assign req       = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit       = req & rentry.valid & (rentry.tag == tag);
  // REFILL_DONE already hits but must still stall for its one cycle
  assign cpu_stall_o = req & ((state != IDLE) | !hit);
  assign cpu_data_o  = hit ? rline[{word, 5'd0} +: 32] : '0;
  assign wb = state == WRITEBACK;
  assign rf = state == REFILL;
  assign mem_enable_o = wb | rf;
  assign mem_write_o  = wb;
  assign mem_addr_o   = wb ? {rentry.tag, idx, 5'd0} : rf ? {tag, idx, 5'd0} : '0;
  assign mem_data_o   = wb ? rline : '0;
  always_comb begin
    merged = rline;
    merged[{word, 5'd0} +: 32] = cpu_data_i;
  end
  // a store writes only on the IDLE hit edge, when the pipeline also advances
  assign we     = (state == IDLE & hit & cpu_MemWrite_i) | (rf & mem_ack_i);
  assign wentry = rf ? '{valid: 1'b1, dirty: 1'b0, tag: tag} : '{valid: 1'b1, dirty: 1'b1, tag: tag};
  assign wline  = rf ? mem_data_i : merged;
  dcache_sram u_sram (
    .clk_i  (clk_i),
    .start_i(start_i),
    .idx    (idx),
    .we     (we),
    .wentry (wentry),
    .wline  (wline),
    .rentry (rentry),
    .rline  (rline)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = (req & !hit) ? MISS : IDLE;
      MISS:        state_nx = (rentry.valid & rentry.dirty) ? WRITEBACK : REFILL;
      WRITEBACK:   state_nx = mem_ack_i ? REFILL : WRITEBACK;
      REFILL:      state_nx = mem_ack_i ? REFILL_DONE : REFILL;
      REFILL_DONE: state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) state <= IDLE;
    else          state <= state_nx;
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed checks of hits, clean/dirty misses, ack delay and reset abort
module tb_dcache_controller;
  import cache_pkg::*;
  logic              clk_i = 0, start_i = 0;
  logic [31:0]       cpu_addr_i = 0, cpu_data_i = 0, cpu_data_o, mem_addr_o;
  logic              cpu_MemRead_i = 0, cpu_MemWrite_i = 0, cpu_stall_o;
  logic              mem_enable_o, mem_write_o, mem_ack_i = 0;
  logic [LINE_W-1:0] mem_data_o, mem_data_i = 0;
  int                tests = 0, fails = 0;
  int                ack_dly = 1, cnt = 0, en_run = 0, st;
  logic [31:0]       q;
  logic [LINE_W-1:0] mm [logic [31:0]];
  logic              log_wr[$];
  logic [31:0]       log_addr[$];
  logic [LINE_W-1:0] log_data[$];
  int                log_en[$];
  always #5 clk_i = ~clk_i;
  dcache_controller dut (
    .clk_i         (clk_i),
    .start_i       (start_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_MemRead_i (cpu_MemRead_i),
    .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o    (cpu_data_o),
    .cpu_stall_o   (cpu_stall_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // untouched memory returns each word equal to its own byte address
  function automatic logic [LINE_W-1:0] dflt(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = a + 32'(k * 4);
    return l;
  endfunction
  // memory model: acks after ack_dly enable-high cycles and logs every transaction
  always @(negedge clk_i) begin
    if (!mem_enable_o) begin
      mem_ack_i = 0;
      cnt = 0;
      en_run = 0;
    end else begin
      en_run++;
      if (cnt == ack_dly - 1) begin
        mem_ack_i = 1;
        cnt = 0;
        log_wr.push_back(mem_write_o);
        log_addr.push_back(mem_addr_o);
        log_data.push_back(mem_data_o);
        log_en.push_back(en_run);
        en_run = 0;
        if (mem_write_o) mm[mem_addr_o] = mem_data_o;
        else mem_data_i = mm.exists(mem_addr_o) ? mm[mem_addr_o] : dflt(mem_addr_o);
      end else begin
        mem_ack_i = 0;
        cnt++;
      end
    end
  end
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] data);
    cpu_MemRead_i = rd;
    cpu_MemWrite_i = wr;
    cpu_addr_i = a;
    cpu_data_i = d;
    stalls = 0;
    #1;
    while (cpu_stall_o && stalls < 200) begin
      @(negedge clk_i);
      #1;
      stalls++;
    end
    if (stalls >= 200) check("stall_bound", 32'(stalls), 32'd199);
    data = cpu_data_o;
    @(negedge clk_i);
    #1;
    cpu_MemRead_i = 0;
    cpu_MemWrite_i = 0;
  endtask
  initial begin
    for (int k = 0; k < 8; k++) mm[32'h40][k*32 +: 32] = 32'h1111_1111 * 32'(k + 1);
    repeat (2) @(negedge clk_i);
    #1 start_i = 1;
    #1;
    check("rst_stall", 32'(cpu_stall_o), 0);
    check("rst_en", 32'(mem_enable_o), 0);
    check("rst_wr", 32'(mem_write_o), 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_data", cpu_data_o, 0);
    ack_dly = 2;
    access(1, 0, 32'h40, 0, st, q);
    check("cold_stall", 32'(st), 5);
    check("cold_data", q, 32'h1111_1111);
    check("cold_ntx", 32'(log_addr.size()), 1);
    check("cold_addr", log_addr[0], 32'h40);
    access(0, 1, 32'h44, 32'hDEAD_BEEF, st, q);
    check("wr_stall", 32'(st), 0);
    access(1, 0, 32'h44, 0, st, q);
    check("wr_read", q, 32'hDEAD_BEEF);
    check("wr_ntx", 32'(log_addr.size()), 1);
    check("wr_dirty", 32'(dut.u_sram.dirty_q[2]), 1);
    ack_dly = 1;
    access(1, 0, 32'h240, 0, st, q);
    check("evict_stall", 32'(st), 5);
    check("evict_data", q, 32'h240);
    check("evict_ntx", 32'(log_addr.size()), 3);
    check("wb_is_write", 32'(log_wr[1]), 1);
    check("wb_addr", log_addr[1], 32'h40);
    check("wb_word1", log_data[1][63:32], 32'hDEAD_BEEF);
    check("wb_word0", log_data[1][31:0], 32'h1111_1111);
    check("fetch_is_read", 32'(log_wr[2]), 0);
    check("fetch_addr", log_addr[2], 32'h240);
    ack_dly = 7;
    access(1, 0, 32'h44, 0, st, q);
    check("slow_stall", 32'(st), 10);
    check("slow_en_cycles", 32'(log_en[3]), 7);
    check("slow_addr", log_addr[3], 32'h40);
    check("slow_data", q, 32'hDEAD_BEEF);
    check("slow_ntx", 32'(log_addr.size()), 4);
    access(1, 0, 32'h5C, 0, st, q);
    check("word7_stall", 32'(st), 0);
    check("word7_data", q, 32'h8888_8888);
    access(1, 1, 32'h48, 32'hCAFE_F00D, st, q);
    check("rdwr_stall", 32'(st), 0);
    access(1, 0, 32'h48, 0, st, q);
    check("rdwr_data", q, 32'hCAFE_F00D);
    check("rdwr_ntx", 32'(log_addr.size()), 4);
    ack_dly = 20;
    cpu_MemRead_i = 1;
    cpu_addr_i = 32'h80;
    repeat (5) @(negedge clk_i);
    #1;
    check("abort_pre_en", 32'(mem_enable_o), 1);
    #2 start_i = 0;
    #1;
    check("abort_en", 32'(mem_enable_o), 0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk_i);
    #1 start_i = 1;
    cpu_MemRead_i = 0;
    ack_dly = 1;
    access(1, 0, 32'h80, 0, st, q);
    check("remiss_stall", 32'(st), 4);
    check("remiss_data", q, 32'h80);
    check("remiss_ntx", 32'(log_addr.size()), 5);
    check("remiss_addr", log_addr[4], 32'h80);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
